// File: rtl/serial_word_tx.sv
// serial_word_tx
// Serializes a BITS-wide parallel word into a framed bit stream:
// START (0), BITS data bits LSB first, optional even-parity bit, STOP (1).
// Every bit lasts DIV clock cycles. A shift_en strobe marks the last cycle
// of every data bit, so a downstream shift-right register clocked by the
// same clk reassembles the original word.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active low
//   load_valid  upstream offers a word on Din
//   load_ready  block accepts a word this cycle (IDLE or last STOP cycle)
//   Din         parallel word, captured on the handshake edge
//   tx_serial   registered serial line (idles high)
//   shift_en    one-cycle strobe at the end of each data bit period
//   busy        high while a frame is in progress
//   frame_done  one-cycle pulse on the final STOP cycle
module serial_word_tx #(
  parameter int BITS      = 4,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [BITS-1:0] Din,
  output logic            tx_serial,
  output logic            shift_en,
  output logic            busy,
  output logic            frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(BITS);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  // Counter value one cycle before the last one; only meaningful when DIV > 1.
  localparam logic [CW-1:0] CNT_PRE    = (DIV > 1) ? CW'(DIV - 2) : {CW{1'b0}};
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS - 1);
  // With DIV == 1 the first cycle of a bit period is also its last cycle.
  localparam logic          ONE_CYCLE  = (DIV == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [BW-1:0]   bit_r;
  logic [BITS-1:0] buf_r;
  logic            par_r;
  logic            tx_r;
  logic            shift_en_r;
  logic            busy_r;
  logic            frame_done_r;
  logic            load_ready_r;

  logic            hs_s;
  logic            last_s;
  logic            pre_s;

  // Even parity: XOR of all bits of the word.
  function automatic logic even_parity(input logic [BITS-1:0] word);
    logic p;
    p = 1'b0;
    for (int i = 0; i < BITS; i++) begin
      p = p ^ word[i];
    end
    return p;
  endfunction

  assign hs_s   = load_valid & load_ready_r;
  assign last_s = (cnt_r == CNT_LAST);
  assign pre_s  = (cnt_r == CNT_PRE);

  assign load_ready = load_ready_r;
  assign tx_serial  = tx_r;
  assign shift_en   = shift_en_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Frame FSM. Every output register is loaded with the value that belongs
  // to the cycle being entered, so outputs line up exactly with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      bit_r        <= {BW{1'b0}};
      buf_r        <= {BITS{1'b0}};
      par_r        <= 1'b0;
      tx_r         <= 1'b1;
      shift_en_r   <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      load_ready_r <= 1'b1;
    end else begin
      shift_en_r   <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            state_r      <= START;
            cnt_r        <= {CW{1'b0}};
            buf_r        <= Din;
            par_r        <= even_parity(Din);
            tx_r         <= 1'b0;
            busy_r       <= 1'b1;
            load_ready_r <= 1'b0;
          end else begin
            state_r      <= IDLE;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            load_ready_r <= 1'b1;
          end
        end

        START: begin
          if (last_s) begin
            state_r    <= DATA;
            cnt_r      <= {CW{1'b0}};
            bit_r      <= {BW{1'b0}};
            tx_r       <= buf_r[0];
            shift_en_r <= ONE_CYCLE;
          end else begin
            cnt_r      <= cnt_r + 1'b1;
          end
        end

        DATA: begin
          if (last_s) begin
            cnt_r <= {CW{1'b0}};
            if (bit_r == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state_r      <= PARITY;
                tx_r         <= par_r;
              end else begin
                state_r      <= STOP;
                tx_r         <= 1'b1;
                frame_done_r <= ONE_CYCLE;
                load_ready_r <= ONE_CYCLE;
              end
            end else begin
              // Next data bit: the buffer shifts right so bit 0 is always current.
              bit_r      <= bit_r + 1'b1;
              buf_r      <= buf_r >> 1;
              tx_r       <= buf_r[1];
              shift_en_r <= ONE_CYCLE;
            end
          end else begin
            cnt_r      <= cnt_r + 1'b1;
            shift_en_r <= pre_s;
          end
        end

        PARITY: begin
          if (last_s) begin
            state_r      <= STOP;
            cnt_r        <= {CW{1'b0}};
            tx_r         <= 1'b1;
            frame_done_r <= ONE_CYCLE;
            load_ready_r <= ONE_CYCLE;
          end else begin
            cnt_r        <= cnt_r + 1'b1;
          end
        end

        STOP: begin
          if (last_s) begin
            cnt_r <= {CW{1'b0}};
            if (hs_s) begin
              // Back-to-back frame: START follows with no idle gap.
              state_r      <= START;
              buf_r        <= Din;
              par_r        <= even_parity(Din);
              tx_r         <= 1'b0;
              busy_r       <= 1'b1;
              load_ready_r <= 1'b0;
            end else begin
              state_r      <= IDLE;
              tx_r         <= 1'b1;
              busy_r       <= 1'b0;
              load_ready_r <= 1'b1;
            end
          end else begin
            cnt_r        <= cnt_r + 1'b1;
            frame_done_r <= pre_s;
            load_ready_r <= pre_s;
          end
        end

        default: begin
          state_r      <= IDLE;
          cnt_r        <= {CW{1'b0}};
          bit_r        <= {BW{1'b0}};
          buf_r        <= {BITS{1'b0}};
          par_r        <= 1'b0;
          tx_r         <= 1'b1;
          busy_r       <= 1'b0;
          load_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Testbench for serial_word_tx. Two instances share the clock and reset:
// dut_a (BITS=4, DIV=4, PARITY_EN=1) and dut_b (BITS=4, DIV=1, PARITY_EN=0).
// 'sel' chooses which instance the tasks drive and observe. Expected
// waveforms come from a frame model built from the bit-period arithmetic.
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       lv;
  logic [3:0] din;

  int errors = 0;
  int checks = 0;

  logic       lv_a, ready_a, tx_a, sh_a, busy_a, done_a;
  logic       lv_b, ready_b, tx_b, sh_b, busy_b, done_b;
  logic       ready_o, tx_o, sh_o, busy_o, done_o;

  always #5 clk = ~clk;

  assign lv_a    = sel ? 1'b0 : lv;
  assign lv_b    = sel ? lv : 1'b0;
  assign ready_o = sel ? ready_b : ready_a;
  assign tx_o    = sel ? tx_b    : tx_a;
  assign sh_o    = sel ? sh_b    : sh_a;
  assign busy_o  = sel ? busy_b  : busy_a;
  assign done_o  = sel ? done_b  : done_a;

  serial_word_tx #(.BITS(4), .DIV(4), .PARITY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .load_valid(lv_a), .load_ready(ready_a),
    .Din(din), .tx_serial(tx_a), .shift_en(sh_a), .busy(busy_a),
    .frame_done(done_a)
  );

  serial_word_tx #(.BITS(4), .DIV(1), .PARITY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .load_valid(lv_b), .load_ready(ready_b),
    .Din(din), .tx_serial(tx_b), .shift_en(sh_b), .busy(busy_b),
    .frame_done(done_b)
  );

  // Present a word with load_valid; the handshake happens on the next rising edge.
  task automatic start_frame(input logic [3:0] w);
    @(negedge clk);
    lv  = 1'b1;
    din = w;
  endtask

  // Check one complete frame cycle by cycle, starting on its first START cycle.
  task automatic check_frame(input logic [3:0] w, input bit scramble, input bit hold_lv,
                             input bit next_valid, input logic [3:0] next_word);
    int div, pen, len, p;
    logic e_tx, e_sh, e_last;
    logic [3:0] ds;
    div = sel ? 1 : 4;
    pen = sel ? 0 : 1;
    len = (4 + 2 + pen) * div;
    ds  = 4'b0000;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      p = c / div;
      if (p == 0)                 e_tx = 1'b0;
      else if (p <= 4)            e_tx = w[p-1];
      else if (pen == 1 && p == 5) e_tx = ^w;
      else                        e_tx = 1'b1;
      e_sh   = (p >= 1 && p <= 4 && (c % div) == div - 1);
      e_last = (c == len - 1);
      checks++;
      if (tx_o !== e_tx) begin
        errors++;
        $display("FAIL tx_serial word=%b cycle=%0d got=%b exp=%b", w, c, tx_o, e_tx);
      end
      checks++;
      if (sh_o !== e_sh) begin
        errors++;
        $display("FAIL shift_en word=%b cycle=%0d got=%b exp=%b", w, c, sh_o, e_sh);
      end
      checks++;
      if (busy_o !== 1'b1) begin
        errors++;
        $display("FAIL busy word=%b cycle=%0d got=%b exp=1", w, c, busy_o);
      end
      checks++;
      if (done_o !== e_last) begin
        errors++;
        $display("FAIL frame_done word=%b cycle=%0d got=%b exp=%b", w, c, done_o, e_last);
      end
      checks++;
      if (ready_o !== e_last) begin
        errors++;
        $display("FAIL load_ready word=%b cycle=%0d got=%b exp=%b", w, c, ready_o, e_last);
      end
      // Downstream shift-right register: serial bit enters at the MSB.
      if (sh_o === 1'b1) ds = {tx_o, ds[3:1]};
      if (c == len - 1) begin
        lv  = next_valid;
        din = next_word;
      end else begin
        lv = hold_lv;
        if (scramble) din = 4'($urandom);
      end
    end
    checks++;
    if (ds !== w) begin
      errors++;
      $display("FAIL downstream_word got=%b exp=%b", ds, w);
    end
  endtask

  // One cycle after a frame without a follow-on handshake the line must be idle.
  task automatic check_idle(input string tag);
    @(negedge clk);
    checks++;
    if ({tx_o, sh_o, busy_o, done_o, ready_o} !== 5'b10001) begin
      errors++;
      $display("FAIL idle_%s got tx/sh/busy/done/ready=%b exp=10001", tag,
               {tx_o, sh_o, busy_o, done_o, ready_o});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    lv    = 1'b0;
    din   = 4'b0000;
    sel   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_a, sh_a, busy_a, done_a, ready_a} !== 5'b10001) begin
      errors++;
      $display("FAIL reset_a got=%b exp=10001", {tx_a, sh_a, busy_a, done_a, ready_a});
    end
    checks++;
    if ({tx_b, sh_b, busy_b, done_b, ready_b} !== 5'b10001) begin
      errors++;
      $display("FAIL reset_b got=%b exp=10001", {tx_b, sh_b, busy_b, done_b, ready_b});
    end
    reset = 1'b1;
    check_idle("after_reset");
  endtask

  task automatic test_directed_frame();
    sel = 1'b0;
    start_frame(4'b1011);
    check_frame(4'b1011, 1'b0, 1'b0, 1'b0, 4'b0000);
    check_idle("directed");
  endtask

  task automatic test_no_parity_div1();
    sel = 1'b1;
    start_frame(4'b0110);
    check_frame(4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000);
    check_idle("no_parity");
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    start_frame(4'hA);
    check_frame(4'hA, 1'b0, 1'b1, 1'b1, 4'h5);
    check_frame(4'h5, 1'b0, 1'b0, 1'b0, 4'h0);
    check_idle("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0;
    start_frame(4'b1001);
    // Cycles 12..15 of the frame carry data bit 2; abort in cycle 13.
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      lv = 1'b0;
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({tx_a, sh_a, busy_a, done_a, ready_a} !== 5'b10001) begin
      errors++;
      $display("FAIL async_reset got=%b exp=10001", {tx_a, sh_a, busy_a, done_a, ready_a});
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (sh_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d got sh/done/busy=%b exp=000", c, {sh_a, done_a, busy_a});
      end
    end
    // Release and offer a word for the very first rising edge.
    @(negedge clk);
    reset = 1'b1;
    lv    = 1'b1;
    din   = 4'b0111;
    check_frame(4'b0111, 1'b0, 1'b0, 1'b0, 4'b0000);
    check_idle("after_abort");
  endtask

  task automatic test_din_stability();
    sel = 1'b0;
    start_frame(4'b1001);
    check_frame(4'b1001, 1'b1, 1'b0, 1'b0, 4'b0000);
    check_idle("din_scramble");
  endtask

  task automatic test_random_frames();
    logic [3:0] w;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sel = 1'($urandom_range(0, 1));
      w   = 4'($urandom);
      start_frame(w);
      check_frame(w, 1'b1, 1'b0, 1'b0, 4'b0000);
      check_idle("random");
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed_frame();
    test_no_parity_div1();
    test_back_to_back();
    test_reset_mid_frame();
    test_din_stability();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
